adc_window_accumulator: RTL and testbench

ADC_WINDOW_ACCUMULATOR -- requirements
Module: adc_window_accumulator

---
 rtl/adc_window_accumulator_if.sv | 48 ++++
 rtl/adc_window_accumulator.sv | 172 +++++++++++++++++
 tb/tb_adc_window_accumulator.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_window_accumulator_if.sv
// Sample, control and result bundle for the ADC window accumulator.
// The slave modport is the accumulator; the master modport is whoever drives it.
interface adc_window_accumulator_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16,
    parameter int ACC_WIDTH   = 32
);
    logic                          adcValidIn;
    logic signed [DATA_WIDTH-1:0]  adc0In;
    logic signed [DATA_WIDTH-1:0]  adc1In;
    logic signed [DATA_WIDTH-1:0]  adc2In;
    logic signed [DATA_WIDTH-1:0]  adc3In;
    logic signed [DATA_WIDTH-1:0]  adc0QIn;
    logic signed [DATA_WIDTH-1:0]  adc1QIn;
    logic signed [DATA_WIDTH-1:0]  adc2QIn;
    logic signed [DATA_WIDTH-1:0]  adc3QIn;
    logic                          adcUseThisSample;
    logic                          adcExceedsThreshold;
    logic [COUNT_WIDTH-1:0]        windowLength;
    logic                          start;
    logic                          busy;
    logic                          sumValid;
    logic signed [ACC_WIDTH-1:0]   sum0;
    logic signed [ACC_WIDTH-1:0]   sum1;
    logic signed [ACC_WIDTH-1:0]   sum2;
    logic signed [ACC_WIDTH-1:0]   sum3;
    logic signed [ACC_WIDTH-1:0]   sum0Q;
    logic signed [ACC_WIDTH-1:0]   sum1Q;
    logic signed [ACC_WIDTH-1:0]   sum2Q;
    logic signed [ACC_WIDTH-1:0]   sum3Q;
    logic [COUNT_WIDTH-1:0]        exceedCount;

    modport slave (
        input  adcValidIn, adc0In, adc1In, adc2In, adc3In,
               adc0QIn, adc1QIn, adc2QIn, adc3QIn,
               adcUseThisSample, adcExceedsThreshold, windowLength, start,
        output busy, sumValid, sum0, sum1, sum2, sum3,
               sum0Q, sum1Q, sum2Q, sum3Q, exceedCount
    );

    modport master (
        output adcValidIn, adc0In, adc1In, adc2In, adc3In,
               adc0QIn, adc1QIn, adc2QIn, adc3QIn,
               adcUseThisSample, adcExceedsThreshold, windowLength, start,
        input  busy, sumValid, sum0, sum1, sum2, sum3,
               sum0Q, sum1Q, sum2Q, sum3Q, exceedCount
    );
endinterface

// File: rtl/adc_window_accumulator.sv
// Accumulates a fixed-length window of qualified four-channel I/Q ADC samples
// and publishes the eight channel sums plus a threshold-exceed count.
// Channel index order everywhere: 0..3 = I channels 0..3, 4..7 = Q channels 0..3.
module adc_window_accumulator #(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16,
    parameter int ACC_WIDTH   = 32
) (
    input  logic                      adcClk,
    input  logic                      adcReset,
    adc_window_accumulator_if.slave   bus
);

    // The accumulators must hold a full window of worst-case samples.
    generate
        if (ACC_WIDTH < DATA_WIDTH + COUNT_WIDTH) begin : g_width_check
            $error("ACC_WIDTH must be at least DATA_WIDTH+COUNT_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                        state_r;
    state_t                        state_nxt_s;
    logic                          busy_nxt_s;
    logic                          busy_r;
    logic                          sum_valid_r;
    logic                          accept_s;
    logic                          start_ok_s;
    logic                          last_s;
    logic [COUNT_WIDTH-1:0]        len_r;
    logic [COUNT_WIDTH-1:0]        sample_cnt_r;
    logic [COUNT_WIDTH-1:0]        cnt_inc_s;
    logic [COUNT_WIDTH-1:0]        exceed_cnt_r;
    logic [COUNT_WIDTH-1:0]        exceed_out_r;
    logic signed [DATA_WIDTH-1:0]  sample_s [8];
    logic signed [ACC_WIDTH-1:0]   acc_r    [8];
    logic signed [ACC_WIDTH-1:0]   sum_r    [8];

    function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [DATA_WIDTH-1:0] x);
        return {{(ACC_WIDTH-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    endfunction

    assign sample_s[0] = bus.adc0In;
    assign sample_s[1] = bus.adc1In;
    assign sample_s[2] = bus.adc2In;
    assign sample_s[3] = bus.adc3In;
    assign sample_s[4] = bus.adc0QIn;
    assign sample_s[5] = bus.adc1QIn;
    assign sample_s[6] = bus.adc2QIn;
    assign sample_s[7] = bus.adc3QIn;

    // A zero-length request never leaves IDLE; a window counts only qualified strobes.
    assign start_ok_s = (state_r == IDLE) && bus.start && (bus.windowLength != {COUNT_WIDTH{1'b0}});
    assign accept_s   = ((state_r == ARMED) || (state_r == ACCUM)) && bus.adcValidIn && bus.adcUseThisSample;
    assign cnt_inc_s  = sample_cnt_r + COUNT_WIDTH'(1);
    assign last_s     = (cnt_inc_s == len_r);

    // State register; reset wins over every other event in the cycle.
    always_ff @(posedge adcClk) begin
        if (adcReset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ARMED;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARMED, ACCUM: begin
                if (accept_s && last_s) begin
                    state_nxt_s = DONE;
                end else if (accept_s) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode: busy is taken from the next state so it can be registered.
    always_comb begin
        busy_nxt_s = 1'b0;
        if ((state_nxt_s == ARMED) || (state_nxt_s == ACCUM)) begin
            busy_nxt_s = 1'b1;
        end else begin
            busy_nxt_s = 1'b0;
        end
    end

    // Window datapath: latch length, accumulate accepted samples, publish in DONE.
    always_ff @(posedge adcClk) begin
        if (adcReset) begin
            busy_r       <= 1'b0;
            sum_valid_r  <= 1'b0;
            len_r        <= {COUNT_WIDTH{1'b0}};
            sample_cnt_r <= {COUNT_WIDTH{1'b0}};
            exceed_cnt_r <= {COUNT_WIDTH{1'b0}};
            exceed_out_r <= {COUNT_WIDTH{1'b0}};
            for (int i = 0; i < 8; i++) begin
                acc_r[i] <= {ACC_WIDTH{1'b0}};
                sum_r[i] <= {ACC_WIDTH{1'b0}};
            end
        end else begin
            busy_r      <= busy_nxt_s;
            sum_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_ok_s) begin
                        len_r        <= bus.windowLength;
                        sample_cnt_r <= {COUNT_WIDTH{1'b0}};
                        exceed_cnt_r <= {COUNT_WIDTH{1'b0}};
                        for (int i = 0; i < 8; i++) begin
                            acc_r[i] <= {ACC_WIDTH{1'b0}};
                        end
                    end
                end
                ARMED, ACCUM: begin
                    if (accept_s) begin
                        sample_cnt_r <= cnt_inc_s;
                        if (bus.adcExceedsThreshold) begin
                            exceed_cnt_r <= exceed_cnt_r + COUNT_WIDTH'(1);
                        end
                        for (int i = 0; i < 8; i++) begin
                            acc_r[i] <= acc_r[i] + sext(sample_s[i]);
                        end
                    end
                end
                DONE: begin
                    sum_valid_r  <= 1'b1;
                    exceed_out_r <= exceed_cnt_r;
                    for (int i = 0; i < 8; i++) begin
                        sum_r[i] <= acc_r[i];
                    end
                end
                default: begin
                    sum_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.sumValid    = sum_valid_r;
    assign bus.exceedCount = exceed_out_r;
    assign bus.sum0        = sum_r[0];
    assign bus.sum1        = sum_r[1];
    assign bus.sum2        = sum_r[2];
    assign bus.sum3        = sum_r[3];
    assign bus.sum0Q       = sum_r[4];
    assign bus.sum1Q       = sum_r[5];
    assign bus.sum2Q       = sum_r[6];
    assign bus.sum3Q       = sum_r[7];

endmodule

// File: tb/tb_adc_window_accumulator.sv
// Directed bench for adc_window_accumulator: a window-level reference model is
// compared every cycle, and hand-computed results pin each scenario.
module tb_adc_window_accumulator;

    logic adcClk;
    logic adcReset;
    int   checks;
    int   errors;

    adc_window_accumulator_if #(.DATA_WIDTH(16), .COUNT_WIDTH(16), .ACC_WIDTH(32)) bus ();

    adc_window_accumulator #(.DATA_WIDTH(16), .COUNT_WIDTH(16), .ACC_WIDTH(32)) dut (
        .adcClk   (adcClk),
        .adcReset (adcReset),
        .bus      (bus)
    );

    initial begin
        adcClk = 1'b0;
        forever #5 adcClk = ~adcClk;
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- window-level reference model ----------------
    // A window opens on a valid start while nothing is in flight, collects the
    // latched number of qualified samples, and its result appears one clock
    // after the last one; the clock in which the result appears ignores start.
    bit     m_en;
    bit     m_active;
    bit     m_pend;
    bit     m_valid;
    int     m_left;
    longint m_run [8];
    longint m_out [8];
    int     m_exc_run;
    int     m_exc_out;
    longint smp   [8];

    always @(posedge adcClk) begin
        smp[0] = longint'(bus.adc0In);  smp[1] = longint'(bus.adc1In);
        smp[2] = longint'(bus.adc2In);  smp[3] = longint'(bus.adc3In);
        smp[4] = longint'(bus.adc0QIn); smp[5] = longint'(bus.adc1QIn);
        smp[6] = longint'(bus.adc2QIn); smp[7] = longint'(bus.adc3QIn);
        if (adcReset) begin
            m_en = 1'b1; m_active = 1'b0; m_pend = 1'b0; m_valid = 1'b0;
            m_left = 0; m_exc_run = 0; m_exc_out = 0;
            for (int i = 0; i < 8; i++) begin m_run[i] = 0; m_out[i] = 0; end
        end else begin
            m_valid = 1'b0;
            if (m_pend) begin
                for (int i = 0; i < 8; i++) m_out[i] = m_run[i];
                m_exc_out = m_exc_run;
                m_valid = 1'b1;
                m_pend = 1'b0;
            end else if (!m_active) begin
                if (bus.start && (bus.windowLength != 16'd0)) begin
                    m_active = 1'b1;
                    m_left = int'(bus.windowLength);
                    m_exc_run = 0;
                    for (int i = 0; i < 8; i++) m_run[i] = 0;
                end
            end else if (bus.adcValidIn && bus.adcUseThisSample) begin
                for (int i = 0; i < 8; i++) m_run[i] += smp[i];
                if (bus.adcExceedsThreshold) m_exc_run++;
                m_left--;
                if (m_left == 0) begin
                    m_active = 1'b0;
                    m_pend = 1'b1;
                end
            end
        end
        #1;
        if (m_en) begin
            chk("m_busy",     bus.busy,        m_active);
            chk("m_sumValid", bus.sumValid,    m_valid);
            chk("m_exceed",   bus.exceedCount, m_exc_out);
            chk("m_sum0",     bus.sum0,  m_out[0]);
            chk("m_sum1",     bus.sum1,  m_out[1]);
            chk("m_sum2",     bus.sum2,  m_out[2]);
            chk("m_sum3",     bus.sum3,  m_out[3]);
            chk("m_sum0Q",    bus.sum0Q, m_out[4]);
            chk("m_sum1Q",    bus.sum1Q, m_out[5]);
            chk("m_sum2Q",    bus.sum2Q, m_out[6]);
            chk("m_sum3Q",    bus.sum3Q, m_out[7]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge adcClk);
    endtask

    task automatic clr_in();
        bus.adcValidIn = 1'b0; bus.adcUseThisSample = 1'b0; bus.adcExceedsThreshold = 1'b0;
        bus.adc0In = 16'sd0;  bus.adc1In = 16'sd0;  bus.adc2In = 16'sd0;  bus.adc3In = 16'sd0;
        bus.adc0QIn = 16'sd0; bus.adc1QIn = 16'sd0; bus.adc2QIn = 16'sd0; bus.adc3QIn = 16'sd0;
    endtask

    task automatic set_ch(input int ch, input logic signed [15:0] v);
        case (ch)
            0: bus.adc0In = v;
            1: bus.adc1In = v;
            2: bus.adc2In = v;
            3: bus.adc3In = v;
            4: bus.adc0QIn = v;
            5: bus.adc1QIn = v;
            6: bus.adc2QIn = v;
            7: bus.adc3QIn = v;
            default: bus.adc0In = bus.adc0In;
        endcase
    endtask

    task automatic samp(input int ch, input logic signed [15:0] v, input logic use_q, input logic exc);
        clr_in();
        bus.adcValidIn = 1'b1;
        bus.adcUseThisSample = use_q;
        bus.adcExceedsThreshold = exc;
        set_ch(ch, v);
        tick();
    endtask

    task automatic do_start(input logic [15:0] wl);
        clr_in();
        bus.windowLength = wl;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Returns the number of negedges until sumValid is seen, or -1 on timeout.
    task automatic wait_valid(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.sumValid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat;
    int busy_seen;
    int valid_seen;

    initial begin
        checks = 0; errors = 0;
        m_en = 1'b0;
        adcReset = 1'b1;
        bus.start = 1'b0;
        bus.windowLength = 16'd0;
        clr_in();
        repeat (3) tick();
        chk("reset_busy",   bus.busy,        1'b0);
        chk("reset_valid",  bus.sumValid,    1'b0);
        chk("reset_sum0",   bus.sum0,        0);
        chk("reset_exceed", bus.exceedCount, 0);
        adcReset = 1'b0;
        tick();

        // Four samples on I channel 0, with a start attempted mid-window.
        do_start(16'd4);
        chk("armed_busy", bus.busy, 1'b1);
        samp(0, 16'sd20, 1'b1, 1'b0);
        samp(0, 16'sd40, 1'b1, 1'b0);
        bus.start = 1'b1; bus.windowLength = 16'd2;
        samp(0, 16'sd60, 1'b1, 1'b0);
        bus.start = 1'b0;
        samp(0, 16'sd80, 1'b1, 1'b0);
        clr_in();
        wait_valid(10, lat);
        chk("w4_latency", lat, 1);
        chk("w4_sum0",    bus.sum0, 200);
        chk("w4_sum1",    bus.sum1, 0);
        chk("w4_exceed",  bus.exceedCount, 0);
        tick();
        chk("w4_pulse_one_cycle", bus.sumValid, 1'b0);

        // Qualifier toggling on Q channel 1.
        do_start(16'd3);
        samp(5, -16'sd100, 1'b1, 1'b0);
        samp(5, -16'sd200, 1'b0, 1'b0);
        samp(5, -16'sd300, 1'b1, 1'b0);
        samp(5, -16'sd300, 1'b0, 1'b0);
        samp(5, -16'sd300, 1'b1, 1'b0);
        clr_in();
        wait_valid(10, lat);
        chk("q_latency", lat, 1);
        chk("q_sum1Q",   bus.sum1Q, -700);

        // Exceed flag on accepted samples 2 and 4 only; length changed after start.
        do_start(16'd5);
        bus.windowLength = 16'd2;
        samp(6, 16'sd1, 1'b1, 1'b0);
        samp(6, 16'sd9, 1'b0, 1'b1);
        samp(6, 16'sd2, 1'b1, 1'b1);
        samp(6, 16'sd3, 1'b1, 1'b0);
        clr_in();
        bus.adcExceedsThreshold = 1'b1;
        tick();
        samp(6, 16'sd4, 1'b1, 1'b1);
        samp(6, 16'sd5, 1'b1, 1'b0);
        clr_in();
        wait_valid(10, lat);
        chk("exc_latency", lat, 1);
        chk("exc_count",   bus.exceedCount, 2);
        chk("exc_sum2Q",   bus.sum2Q, 15);
        repeat (5) tick();
        chk("hold_sum2Q",   bus.sum2Q, 15);
        chk("hold_exceed",  bus.exceedCount, 2);

        // Single-sample window; a start in the publishing cycle is dropped.
        do_start(16'd1);
        samp(0, -16'sd5, 1'b1, 1'b0);
        clr_in();
        bus.start = 1'b1; bus.windowLength = 16'd2;
        tick();
        bus.start = 1'b0;
        chk("w1_valid", bus.sumValid, 1'b1);
        chk("w1_sum0",  bus.sum0, -5);
        chk("w1_busy",  bus.busy, 1'b0);
        repeat (3) tick();
        chk("w1_start_dropped", bus.busy, 1'b0);

        // Zero-length start is ignored even with samples streaming.
        bus.windowLength = 16'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.adcValidIn = 1'b1; bus.adcUseThisSample = 1'b1; bus.adc0In = 16'sd3;
        busy_seen = 0; valid_seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.busy !== 1'b0) busy_seen++;
            if (bus.sumValid !== 1'b0) valid_seen++;
        end
        chk("zero_busy",  busy_seen, 0);
        chk("zero_valid", valid_seen, 0);
        chk("zero_sum0",  bus.sum0, -5);
        clr_in();

        // Reset mid-window beats a simultaneous start and sample.
        do_start(16'd8);
        samp(3, 16'sd5, 1'b1, 1'b1);
        samp(3, 16'sd5, 1'b1, 1'b1);
        samp(3, 16'sd5, 1'b1, 1'b1);
        adcReset = 1'b1;
        bus.start = 1'b1; bus.windowLength = 16'd4;
        bus.adcValidIn = 1'b1; bus.adcUseThisSample = 1'b1; bus.adc3In = 16'sd5;
        tick();
        chk("rst_busy",   bus.busy, 1'b0);
        chk("rst_valid",  bus.sumValid, 1'b0);
        chk("rst_sum0",   bus.sum0, 0);
        chk("rst_sum2Q",  bus.sum2Q, 0);
        chk("rst_exceed", bus.exceedCount, 0);
        adcReset = 1'b0;
        bus.start = 1'b0;
        clr_in();
        tick();
        chk("rst_start_dropped", bus.busy, 1'b0);
        do_start(16'd2);
        samp(3, 16'sd7, 1'b1, 1'b0);
        samp(3, 16'sd7, 1'b1, 1'b0);
        clr_in();
        wait_valid(10, lat);
        chk("post_rst_latency", lat, 1);
        chk("post_rst_sum3",    bus.sum3, 14);

        // Full-length window of most-negative samples must not wrap.
        do_start(16'd65535);
        clr_in();
        bus.adcValidIn = 1'b1; bus.adcUseThisSample = 1'b1; bus.adc2In = -16'sd32768;
        repeat (65535) tick();
        clr_in();
        wait_valid(10, lat);
        chk("max_latency", lat, 1);
        chk("max_sum2",    bus.sum2, -64'sd2147450880);
        chk("max_sum0",    bus.sum0, 0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
